// File: rtl/mc_store_tracker.sv
// mc_store_tracker
//   Store-completion tracker for the memory controller. Counts stores
//   announced by per-basic-block control tokens, retires one per write-arbiter
//   completion pulse, and emits the memory-end token once the function-exit
//   token has been seen and every announced store has been issued.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   ctrl            NUM_CTRL store-count tokens, channel i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   ctrl_valid      per-channel token valid
//   ctrl_ready      per-channel token ready (all ones unless DONE)
//   store_done      one-cycle completion pulses, one bit per store port
//   end_valid       function-exit token valid
//   end_ready       function-exit token ready (RUN only)
//   mem_end_valid   memory-end token valid (DONE only)
//   mem_end_ready   memory-end token ready
//   pending         current pending-store counter
//   underflow       sticky: completions exceeded announced stores
module mc_store_tracker #(
  parameter int NUM_CTRL    = 2,
  parameter int CTRL_WIDTH  = 32,
  parameter int NUM_STORES  = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CTRL*CTRL_WIDTH-1:0] ctrl,
  input  logic [NUM_CTRL-1:0]            ctrl_valid,
  output logic [NUM_CTRL-1:0]            ctrl_ready,
  input  logic [NUM_STORES-1:0]          store_done,
  input  logic                           end_valid,
  output logic                           end_ready,
  output logic                           mem_end_valid,
  input  logic                           mem_end_ready,
  output logic [COUNT_WIDTH-1:0]         pending,
  output logic                           underflow
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] counter;
  logic [NUM_CTRL-1:0]    ctrl_hs;
  logic                   any_ctrl;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] done_cnt;
  logic [COUNT_WIDTH-1:0] counter_next;
  logic [COUNT_WIDTH:0]   credit;
  logic                   underflow_now;

  function automatic logic [COUNT_WIDTH-1:0] count_ones(input logic [NUM_STORES-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_STORES; i++)
      n = n + COUNT_WIDTH'(v[i]);
    return n;
  endfunction

  // Every valid channel is taken in the same cycle; no arbitration.
  assign ctrl_hs  = ctrl_valid & ctrl_ready;
  assign any_ctrl = |ctrl_hs;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_CTRL; i++)
      if (ctrl_hs[i])
        acc = acc + COUNT_WIDTH'(ctrl[i*CTRL_WIDTH +: CTRL_WIDTH]);
  end

  assign done_cnt      = count_ones(store_done);
  assign counter_next  = counter + acc - done_cnt;
  // One extra bit so the underflow test is done without wrap-around.
  assign credit        = {1'b0, counter} + {1'b0, acc};
  assign underflow_now = credit < {1'b0, done_cnt};

  assign pending = counter;

  // Handshake outputs are flops updated together with the state so they are
  // never decoded from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      counter       <= '0;
      underflow     <= 1'b0;
      mem_end_valid <= 1'b0;
      end_ready     <= 1'b1;
      ctrl_ready    <= '1;
    end else begin
      counter <= counter_next;
      if (underflow_now)
        underflow <= 1'b1;
      case (state)
        RUN: begin
          if (end_valid) begin
            state     <= DRAIN;
            end_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // A token announced in the final cycle keeps us draining.
          if (counter_next == '0 && !any_ctrl) begin
            state         <= DONE;
            mem_end_valid <= 1'b1;
            ctrl_ready    <= '0;
          end
        end
        DONE: begin
          if (mem_end_ready) begin
            state         <= RUN;
            mem_end_valid <= 1'b0;
            end_ready     <= 1'b1;
            ctrl_ready    <= '1;
          end
        end
        default: begin
          state         <= RUN;
          mem_end_valid <= 1'b0;
          end_ready     <= 1'b1;
          ctrl_ready    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_store_tracker.sv
module tb_mc_store_tracker;
  localparam int NC = 2;
  localparam int CW = 32;
  localparam int NS = 2;
  localparam int W  = 32;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC*CW-1:0] ctrl;
  logic [NC-1:0]    ctrl_valid;
  logic [NC-1:0]    ctrl_ready;
  logic [NS-1:0]    store_done;
  logic             end_valid;
  logic             end_ready;
  logic             mem_end_valid;
  logic             mem_end_ready;
  logic [W-1:0]     pending;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: pending count as plain integer, phase 0=run 1=drain 2=done
  longint unsigned m_pend;
  bit              m_uf;
  int              m_phase;

  mc_store_tracker #(
    .NUM_CTRL(NC), .CTRL_WIDTH(CW), .NUM_STORES(NS), .COUNT_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready), .store_done(store_done), .end_valid(end_valid),
    .end_ready(end_ready), .mem_end_valid(mem_end_valid),
    .mem_end_ready(mem_end_ready), .pending(pending), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_uf    = 1'b0;
    m_phase = 0;
  endtask

  task automatic model_step();
    longint unsigned acc;
    longint unsigned full;
    longint unsigned nxt;
    int dn;
    bit hs;
    acc = 0;
    dn  = 0;
    hs  = 1'b0;
    if (m_phase != 2)
      for (int i = 0; i < NC; i++)
        if (ctrl_valid[i]) begin
          acc = acc + longint'(ctrl[i*CW +: CW]);
          hs  = 1'b1;
        end
    acc = acc % MOD;
    for (int i = 0; i < NS; i++)
      dn += int'(store_done[i]);
    full = m_pend + acc;
    if (full < longint'(dn))
      m_uf = 1'b1;
    nxt = (full + MOD - longint'(dn)) % MOD;
    case (m_phase)
      0: if (end_valid) m_phase = 1;
      1: if (nxt == 0 && !hs) m_phase = 2;
      default: if (mem_end_ready) m_phase = 0;
    endcase
    m_pend = nxt;
  endtask

  task automatic check_outputs();
    chk("pending", longint'(pending), m_pend);
    chk("underflow", longint'(underflow), longint'(m_uf));
    chk("mem_end_valid", longint'(mem_end_valid), (m_phase == 2) ? 1 : 0);
    chk("end_ready", longint'(end_ready), (m_phase == 0) ? 1 : 0);
    chk("ctrl_ready", longint'(ctrl_ready), (m_phase == 2) ? 0 : 3);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic cyc(input logic [1:0] cv, input logic [31:0] c0, input logic [31:0] c1,
                     input logic [1:0] sd, input logic ev, input logic mr);
    ctrl_valid    = cv;
    ctrl          = {c1, c0};
    store_done    = sd;
    end_valid     = ev;
    mem_end_ready = mr;
    tick();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    ctrl_valid = '0; ctrl = '0; store_done = '0; end_valid = 1'b0; mem_end_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pending", longint'(pending), 0);
    chk("rst_end_ready", longint'(end_ready), 1);
    chk("rst_mem_end_valid", longint'(mem_end_valid), 0);
    chk("rst_underflow", longint'(underflow), 0);
    chk("rst_ctrl_ready", longint'(ctrl_ready), 3);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl_valid = '0; ctrl = '0; store_done = '0; end_valid = 1'b0; mem_end_ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Basic: announce 3, retire one per cycle, then end.
    cyc(2'b01, 3, 0, 2'b00, 0, 0);
    chk("basic_p3", longint'(pending), 3);
    repeat (3) cyc(2'b00, 0, 0, 2'b01, 0, 0);
    chk("basic_p0", longint'(pending), 0);
    cyc(2'b00, 0, 0, 2'b00, 1, 0);
    chk("basic_drain_mev", longint'(mem_end_valid), 0);
    cyc(2'b00, 0, 0, 2'b00, 0, 0);
    chk("basic_mem_end", longint'(mem_end_valid), 1);
    cyc(2'b00, 0, 0, 2'b00, 0, 1);

    // Early end with two channels in the same cycle.
    cyc(2'b11, 2, 1, 2'b00, 1, 0);
    chk("early_p3", longint'(pending), 3);
    cyc(2'b00, 0, 0, 2'b11, 0, 0);
    chk("early_p1", longint'(pending), 1);
    cyc(2'b00, 0, 0, 2'b01, 0, 0);
    cyc(2'b00, 0, 0, 2'b00, 0, 1);

    // Late ctrl in DRAIN, then back-pressure in DONE.
    cyc(2'b01, 1, 0, 2'b00, 1, 0);
    cyc(2'b10, 0, 4, 2'b01, 0, 0);
    chk("late_p4", longint'(pending), 4);
    chk("late_no_done", longint'(mem_end_valid), 0);
    repeat (4) cyc(2'b00, 0, 0, 2'b01, 0, 0);
    chk("late_done", longint'(mem_end_valid), 1);
    repeat (5) cyc(2'b01, 7, 0, 2'b00, 1, 0);
    chk("bp_hold", longint'(mem_end_valid), 1);
    cyc(2'b00, 0, 0, 2'b00, 0, 1);
    chk("bp_run", longint'(end_ready), 1);

    // Zero-valued token.
    cyc(2'b01, 0, 0, 2'b00, 0, 0);

    // Underflow from reset.
    async_reset();
    cyc(2'b00, 0, 0, 2'b11, 0, 0);
    chk("uf_set", longint'(underflow), 1);
    chk("uf_wrap", longint'(pending), 64'hFFFF_FFFE);
    repeat (10) cyc(2'b00, 0, 0, 2'b00, 0, 0);
    chk("uf_sticky", longint'(underflow), 1);

    // Reset in the middle of DRAIN.
    async_reset();
    cyc(2'b01, 5, 0, 2'b00, 1, 0);
    chk("drain_p5", longint'(pending), 5);
    async_reset();
    cyc(2'b00, 0, 0, 2'b00, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  cv;
      logic [1:0]  sd;
      cv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      sd = 2'($urandom);
      if (m_pend < 2) sd = 2'b00;
      cyc(cv, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), sd,
          1'($urandom_range(0, 7) == 0), 1'($urandom));
    end

    // Randomized traffic that may underflow, including huge token values.
    for (int n = 0; n < 100; n++)
      cyc(2'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
